// File: rtl/gpio_debounce_irq.sv
// Avalon-MM GPIO input controller: per-bit 2-FF synchroniser, counter debounce,
// sticky both-edge capture with write-1-to-clear, and a maskable level interrupt.
module gpio_debounce_irq #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            mask_q, mask_d;
  logic [WIDTH-1:0]            cap_q, cap_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic [WIDTH-1:0]            edge_det;
  logic                        wr_en;
  logic                        unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign edge_det = stable_d ^ stable_q;

  // A clear and a new edge in the same cycle leave the bit set.
  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && address == 2'd1) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd2) cap_d = cap_q & ~writedata[WIDTH-1:0];
    cap_d = cap_d | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd1:    readdata_d = 32'(mask_q);
      2'd2:    readdata_d = 32'(cap_q);
      default: readdata_d = 32'(sync2_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule
